// File: rtl/axinarbiter_pkg.sv
// Shared definitions for the AXIN packet arbiter and its round-robin picker.
package axinarbiter_pkg;

  // Arbiter states: IDLE arbitrates, ACTIVE streams the granted packet.
  typedef enum logic {
    AXA_IDLE   = 1'b0,
    AXA_ACTIVE = 1'b1
  } axa_state_t;

  // Width of the BYTES field: log2 of the number of bytes in one beat.
  function automatic int axa_bytes_width(input int dw);
    return $clog2(dw / 8);
  endfunction

  // Width of a source index; never below one bit.
  function automatic int axa_idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/axin_rrpick.sv
// Combinational rotate-priority picker: the first requester strictly after
// 'last' (searching upward with wrap) wins; 'last' itself is checked last.
module axin_rrpick
  import axinarbiter_pkg::*;
#(
  parameter int NIN = 4,
  parameter int LGN = axa_idx_width(NIN)
) (
  input  logic [NIN-1:0] request,
  input  logic [LGN-1:0] last,
  output logic [NIN-1:0] grant,
  output logic [LGN-1:0] index
);

  // Walk the NIN candidate positions in rotated order and keep the first hit.
  always_comb begin
    logic           found;
    logic [LGN:0]   sum;
    logic [LGN-1:0] cand;
    grant = '0;
    index = '0;
    found = 1'b0;
    sum   = '0;
    cand  = '0;
    for (int off = 1; off <= NIN; off++) begin
      sum = {1'b0, last} + (LGN + 1)'(off);
      if (sum >= (LGN + 1)'(NIN)) begin
        sum = sum - (LGN + 1)'(NIN);
      end
      cand = sum[LGN-1:0];
      if (!found && request[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        index       = cand;
      end
    end
  end

endmodule

// File: rtl/axinarbiter.sv
// Packet-atomic round-robin merge of NIN AXIN streams onto one registered
// master port, with source abort pass-through and a stall watchdog.
module axinarbiter
  import axinarbiter_pkg::*;
#(
  parameter int NIN       = 4,
  parameter int DW        = 64,
  parameter int BW        = axa_bytes_width(DW),
  parameter int LGTIMEOUT = 10
) (
  input  logic              S_AXI_ACLK,
  input  logic              S_AXI_ARESET,
  input  logic [NIN-1:0]    S_VALID,
  output logic [NIN-1:0]    S_READY,
  input  logic [NIN*DW-1:0] S_DATA,
  input  logic [NIN*BW-1:0] S_BYTES,
  input  logic [NIN-1:0]    S_LAST,
  input  logic [NIN-1:0]    S_ABORT,
  output logic              M_VALID,
  input  logic              M_READY,
  output logic [DW-1:0]     M_DATA,
  output logic [BW-1:0]     M_BYTES,
  output logic              M_LAST,
  output logic              M_ABORT,
  output logic [NIN-1:0]    o_grant,
  output logic              o_timeout
);

  localparam int LGN = axa_idx_width(NIN);
  // After reset source NIN-1 counts as the last winner, so source 0 wins first.
  localparam logic [LGN-1:0] LAST_RST = LGN'(NIN - 1);
  // One short of all-ones: a further counted idle cycle is the terminal count.
  localparam logic [LGTIMEOUT-1:0] WD_PRE = ~LGTIMEOUT'(1);

  axa_state_t           state_reg, state_next;
  logic [LGN-1:0]       gnt_reg, gnt_next;
  logic [LGN-1:0]       last_gnt_reg, last_gnt_next;
  logic [LGTIMEOUT-1:0] wdog_reg, wdog_next;
  logic                 m_valid_reg, m_valid_next;
  logic [DW-1:0]        m_data_reg, m_data_next;
  logic [BW-1:0]        m_bytes_reg, m_bytes_next;
  logic                 m_last_reg, m_last_next;
  logic                 m_abort_reg, m_abort_next;
  logic                 timeout_reg, timeout_next;

  logic [DW-1:0]        s_data_arr  [NIN];
  logic [BW-1:0]        s_bytes_arr [NIN];
  logic [NIN-1:0]       pick_grant;
  logic [LGN-1:0]       pick_idx;
  logic                 pick_any;
  logic                 active, out_free;
  logic                 g_valid, g_last, g_abort;
  logic                 accept, src_abort, wd_fire;

  axin_rrpick #(
    .NIN (NIN),
    .LGN (LGN)
  ) u_pick (
    .request (S_VALID),
    .last    (last_gnt_reg),
    .grant   (pick_grant),
    .index   (pick_idx)
  );

  assign pick_any = |pick_grant;
  assign active   = (state_reg == AXA_ACTIVE);
  // The output register can take a beat when empty or draining this cycle.
  assign out_free = !m_valid_reg || M_READY;

  // Per-source unpacking, ready and grant vectors.
  for (genvar gi = 0; gi < NIN; gi++) begin : g_src
    assign s_data_arr[gi]  = S_DATA[gi*DW +: DW];
    assign s_bytes_arr[gi] = S_BYTES[gi*BW +: BW];
    assign o_grant[gi]     = active && (gnt_reg == LGN'(gi));
    assign S_READY[gi]     = active && (gnt_reg == LGN'(gi)) && !S_ABORT[gi] && out_free;
  end

  assign g_valid   = S_VALID[gnt_reg];
  assign g_last    = S_LAST[gnt_reg];
  assign g_abort   = S_ABORT[gnt_reg];
  assign accept    = active && g_valid && !g_abort && out_free;
  assign src_abort = active && g_abort;
  // Fires only on a counted idle cycle, so it can never coincide with a beat.
  assign wd_fire   = active && !g_abort && !g_valid && (wdog_reg == WD_PRE);

  // Next-state: arbitration, packet tracking, watchdog and output register.
  always_comb begin
    state_next    = state_reg;
    gnt_next      = gnt_reg;
    last_gnt_next = last_gnt_reg;
    wdog_next     = wdog_reg;
    m_valid_next  = m_valid_reg;
    m_data_next   = m_data_reg;
    m_bytes_next  = m_bytes_reg;
    m_last_next   = m_last_reg;
    m_abort_next  = 1'b0;
    timeout_next  = 1'b0;

    case (state_reg)
      AXA_IDLE: begin
        if (pick_any) begin
          state_next    = AXA_ACTIVE;
          gnt_next      = pick_idx;
          last_gnt_next = pick_idx;
          wdog_next     = '0;
        end
      end
      AXA_ACTIVE: begin
        if (src_abort || wd_fire) begin
          state_next   = AXA_IDLE;
          m_abort_next = 1'b1;
          timeout_next = wd_fire;
          wdog_next    = '0;
        end else if (accept) begin
          wdog_next = '0;
          if (g_last) begin
            state_next = AXA_IDLE;
          end
        end else if (!g_valid) begin
          wdog_next = wdog_reg + LGTIMEOUT'(1);
        end
      end
      default: begin
        state_next = AXA_IDLE;
      end
    endcase

    if (src_abort || wd_fire) begin
      m_valid_next = 1'b0;
    end else if (accept) begin
      m_valid_next = 1'b1;
      m_data_next  = s_data_arr[gnt_reg];
      m_bytes_next = s_bytes_arr[gnt_reg];
      m_last_next  = g_last;
    end else if (M_READY) begin
      m_valid_next = 1'b0;
    end
  end

  // State and output registers; reset clears everything without an abort pulse.
  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      state_reg    <= AXA_IDLE;
      gnt_reg      <= '0;
      last_gnt_reg <= LAST_RST;
      wdog_reg     <= '0;
      m_valid_reg  <= 1'b0;
      m_data_reg   <= '0;
      m_bytes_reg  <= '0;
      m_last_reg   <= 1'b0;
      m_abort_reg  <= 1'b0;
      timeout_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      gnt_reg      <= gnt_next;
      last_gnt_reg <= last_gnt_next;
      wdog_reg     <= wdog_next;
      m_valid_reg  <= m_valid_next;
      m_data_reg   <= m_data_next;
      m_bytes_reg  <= m_bytes_next;
      m_last_reg   <= m_last_next;
      m_abort_reg  <= m_abort_next;
      timeout_reg  <= timeout_next;
    end
  end

  assign M_VALID   = m_valid_reg;
  assign M_DATA    = m_data_reg;
  assign M_BYTES   = m_bytes_reg;
  assign M_LAST    = m_last_reg;
  assign M_ABORT   = m_abort_reg;
  assign o_timeout = timeout_reg;

endmodule

// File: tb/tb_axinarbiter.sv
// Self-checking bench for axinarbiter: directed scenarios plus random traffic,
// all compared against a packet-level reference model.
module tb_axinarbiter;

  localparam int NIN         = 4;
  localparam int DW          = 64;
  localparam int BW          = 3;
  localparam int LGT         = 4;
  localparam int STALL_LIMIT = (1 << LGT) - 1;

  logic              clk;
  logic              rst;
  logic [NIN-1:0]    s_valid, s_ready, s_last, s_abort;
  logic [NIN*DW-1:0] s_data;
  logic [NIN*BW-1:0] s_bytes;
  logic              m_valid, m_ready, m_last, m_abort, timeout;
  logic [DW-1:0]     m_data;
  logic [BW-1:0]     m_bytes;
  logic [NIN-1:0]    grant;

  axinarbiter #(
    .NIN       (NIN),
    .DW        (DW),
    .BW        (BW),
    .LGTIMEOUT (LGT)
  ) dut (
    .S_AXI_ACLK   (clk),
    .S_AXI_ARESET (rst),
    .S_VALID      (s_valid),
    .S_READY      (s_ready),
    .S_DATA       (s_data),
    .S_BYTES      (s_bytes),
    .S_LAST       (s_last),
    .S_ABORT      (s_abort),
    .M_VALID      (m_valid),
    .M_READY      (m_ready),
    .M_DATA       (m_data),
    .M_BYTES      (m_bytes),
    .M_LAST       (m_last),
    .M_ABORT      (m_abort),
    .o_grant      (grant),
    .o_timeout    (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // Reference model: who owns the port, who won last, idle cycles so far,
  // and what the registered output port should be showing.
  bit            m_busy;
  int            m_owner, m_rr, m_stall;
  logic          e_valid, e_last, e_abort, e_to;
  logic [DW-1:0] e_data;
  logic [BW-1:0] e_bytes;

  // Stimulus generator state.
  int             mode;            // 0 manual, 1 random, 2 back-to-back 2-beat packets
  int             gen_left [NIN];
  int             gen_seq  [NIN];
  int             gen_stall[NIN];
  logic [NIN-1:0] acc_vec;
  logic [NIN-1:0] prev_grant;
  int             gnt_log[$];

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    m_busy  = 1'b0;
    m_owner = 0;
    m_rr    = NIN - 1;
    m_stall = 0;
    e_valid = 1'b0;
    e_last  = 1'b0;
    e_abort = 1'b0;
    e_to    = 1'b0;
    e_data  = '0;
    e_bytes = '0;
    acc_vec = '0;
  endtask

  task automatic clear_inputs();
    s_valid = '0;
    s_last  = '0;
    s_abort = '0;
    s_data  = '0;
    s_bytes = '0;
    for (int k = 0; k < NIN; k++) begin
      gen_left[k]  = 0;
      gen_stall[k] = 0;
    end
  endtask

  task automatic drive_src(input int k, input logic v, input logic [DW-1:0] d,
                           input logic [BW-1:0] b, input logic l, input logic a);
    s_valid[k]          = v;
    s_data[k*DW +: DW]  = d;
    s_bytes[k*BW +: BW] = b;
    s_last[k]           = l;
    s_abort[k]          = a;
  endtask

  // Compare every DUT output with what the model expects for this cycle.
  task automatic compare_all();
    logic [NIN-1:0] eg, er;
    eg = '0;
    er = '0;
    if (m_busy) begin
      eg[m_owner] = 1'b1;
      if (!s_abort[m_owner] && (!e_valid || m_ready)) er[m_owner] = 1'b1;
    end
    check_val("o_grant",   grant,   eg);
    check_val("S_READY",   s_ready, er);
    check_val("M_VALID",   m_valid, e_valid);
    check_val("M_DATA",    m_data,  e_data);
    check_val("M_BYTES",   m_bytes, e_bytes);
    check_val("M_LAST",    m_last,  e_last);
    check_val("M_ABORT",   m_abort, e_abort);
    check_val("o_timeout", timeout, e_to);
    if (m_valid && m_ready && m_last)
      $display("cycle %0d: packet end data=%0h bytes=%0d", cyc, m_data, m_bytes);
    if (m_abort)
      $display("cycle %0d: packet aborted (watchdog=%0d)", cyc, timeout);
    if (grant != 0 && prev_grant == 0) begin
      for (int k = 0; k < NIN; k++) if (grant[k]) gnt_log.push_back(k);
    end
    prev_grant = grant;
  endtask

  // Advance the model by one clock using the inputs presented this cycle.
  task automatic model_advance();
    bit acc, kill, to;
    int o;
    o       = m_owner;
    acc     = 1'b0;
    kill    = 1'b0;
    to      = 1'b0;
    acc_vec = '0;
    if (m_busy) begin
      kill = s_abort[o];
      acc  = s_valid[o] && !kill && (!e_valid || m_ready);
      to   = !kill && !s_valid[o] && (m_stall + 1 == STALL_LIMIT);
    end
    e_abort = kill || to;
    e_to    = to;
    if (kill || to) begin
      e_valid = 1'b0;
    end else if (acc) begin
      e_valid = 1'b1;
      e_data  = s_data[o*DW +: DW];
      e_bytes = s_bytes[o*BW +: BW];
      e_last  = s_last[o];
    end else if (m_ready) begin
      e_valid = 1'b0;
    end
    if (!m_busy) begin
      if (s_valid != 0) begin
        for (int i = 1; i <= NIN; i++) begin
          int k;
          k = (m_rr + i) % NIN;
          if (s_valid[k]) begin
            m_owner = k;
            break;
          end
        end
        m_busy  = 1'b1;
        m_rr    = m_owner;
        m_stall = 0;
      end
    end else if (kill || to) begin
      m_busy      = 1'b0;
      gen_left[o] = 0;
    end else if (acc) begin
      m_stall    = 0;
      acc_vec[o] = 1'b1;
      if (gen_left[o] > 0) gen_left[o]--;
      gen_seq[o]++;
      if (s_last[o]) m_busy = 1'b0;
    end else if (!s_valid[o]) begin
      m_stall++;
    end
    for (int k = 0; k < NIN; k++) if (s_abort[k]) gen_left[k] = 0;
  endtask

  // One clock: check at the falling edge, then step the model.
  task automatic step();
    @(negedge clk);
    compare_all();
    model_advance();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Present new source beats; a beat offered but not taken is held.
  task automatic gen_drive();
    m_ready = (mode == 1) ? ($urandom_range(0, 99) < 75) : 1'b1;
    for (int k = 0; k < NIN; k++) begin
      if (s_valid[k] && !acc_vec[k] && !s_abort[k]) continue;
      s_abort[k] = 1'b0;
      if (gen_left[k] == 0) gen_left[k] = (mode == 2) ? 2 : $urandom_range(1, 5);
      if (mode == 1 && gen_stall[k] > 0) begin
        gen_stall[k]--;
        s_valid[k] = 1'b0;
        continue;
      end
      if (mode == 1 && $urandom_range(0, 199) == 0) gen_stall[k] = $urandom_range(8, 20);
      s_valid[k]          = (mode == 2) ? 1'b1 : ($urandom_range(0, 99) < 70);
      s_data[k*DW +: DW]  = {32'(k), 32'(gen_seq[k])};
      s_bytes[k*BW +: BW] = BW'($urandom);
      s_last[k]           = (gen_left[k] == 1);
      if (mode == 1 && $urandom_range(0, 59) == 0) s_abort[k] = 1'b1;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL sim_timeout: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int cnt;
    rst        = 1'b1;
    m_ready    = 1'b1;
    mode       = 0;
    prev_grant = '0;
    clear_inputs();
    for (int k = 0; k < NIN; k++) gen_seq[k] = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_M_VALID", m_valid, 0);
    check_val("rst_M_DATA",  m_data,  0);
    check_val("rst_M_BYTES", m_bytes, 0);
    check_val("rst_M_LAST",  m_last,  0);
    check_val("rst_M_ABORT", m_abort, 0);
    check_val("rst_timeout", timeout, 0);
    check_val("rst_grant",   grant,   0);
    check_val("rst_S_READY", s_ready, 0);
    rst = 1'b0;

    // Fairness: all sources stream 2-beat packets back to back.
    mode = 2;
    gnt_log.delete();
    for (int c = 0; c < 40; c++) begin
      gen_drive();
      step();
    end
    cnt = 0;
    while (m_busy && cnt < 10) begin
      gen_drive();
      step();
      cnt++;
    end
    mode = 0;
    clear_inputs();
    m_ready = 1'b1;
    begin
      int exp_order [5];
      exp_order = '{0, 1, 2, 3, 0};
      for (int i = 0; i < 5; i++)
        check_val("fair_order", (gnt_log.size() > i) ? gnt_log[i] : 99, exp_order[i]);
    end
    step();

    // Single 3-beat packet from source 2.
    drive_src(2, 1, 64'hA0, 0, 0, 0);
    step();
    check_val("sp_grant",  grant,   4'b0100);
    check_val("sp_ready",  s_ready, 4'b0100);
    step();
    check_val("sp_mvalid", m_valid, 1);
    check_val("sp_mdata0", m_data,  64'hA0);
    drive_src(2, 1, 64'hA1, 0, 0, 0);
    step();
    drive_src(2, 1, 64'hA2, 5, 1, 0);
    step();
    check_val("sp_mdata2", m_data,  64'hA2);
    check_val("sp_mlast",  m_last,  1);
    check_val("sp_mbytes", m_bytes, 5);
    drive_src(2, 0, 0, 0, 0, 0);
    step();
    step();

    // Backpressure: M_READY low for 20 cycles mid-packet from source 1.
    drive_src(1, 1, 64'hB0, 0, 0, 0);
    step();
    step();
    drive_src(1, 1, 64'hB1, 0, 0, 0);
    m_ready = 1'b0;
    for (int c = 0; c < 20; c++) begin
      step();
      check_val("bp_mdata",  m_data,  64'hB0);
      check_val("bp_sready", s_ready, 0);
      check_val("bp_tmo",    timeout, 0);
    end
    m_ready = 1'b1;
    step();
    check_val("bp_mdata1", m_data, 64'hB1);
    drive_src(1, 1, 64'hB2, 2, 1, 0);
    step();
    check_val("bp_mdata2", m_data, 64'hB2);
    check_val("bp_mlast",  m_last, 1);
    drive_src(1, 0, 0, 0, 0, 0);
    step();
    step();

    // Source abort: source 1 aborts its 2nd beat while source 2 waits.
    drive_src(1, 1, 64'hC0, 0, 0, 0);
    step();
    step();
    drive_src(1, 1, 64'hC1, 0, 0, 1);
    drive_src(2, 1, 64'hD0, 1, 1, 0);
    step();
    check_val("ab_mabort", m_abort, 1);
    check_val("ab_mvalid", m_valid, 0);
    check_val("ab_grant",  grant,   0);
    drive_src(1, 0, 0, 0, 0, 0);
    step();
    check_val("ab_next",   grant,   4'b0100);
    check_val("ab_pulse",  m_abort, 0);
    step();
    drive_src(2, 0, 0, 0, 0, 0);
    step();
    step();

    // Watchdog: source 0 stops mid-packet.
    drive_src(0, 1, 64'hE0, 0, 0, 0);
    step();
    step();
    drive_src(0, 0, 0, 0, 0, 0);
    cnt = 0;
    while (cnt < 40) begin
      step();
      cnt++;
      if (timeout) break;
    end
    check_val("wd_delay",  cnt,     STALL_LIMIT);
    check_val("wd_mabort", m_abort, 1);
    check_val("wd_mvalid", m_valid, 0);
    check_val("wd_grant",  grant,   0);
    step();
    check_val("wd_pulse",  timeout, 0);
    step();

    // Reset asserted during beat 2 of a packet from source 3.
    drive_src(3, 1, 64'hF0, 0, 0, 0);
    step();
    step();
    drive_src(3, 1, 64'hF1, 0, 0, 0);
    #3;
    rst = 1'b1;
    #1;
    check_val("mr_mvalid", m_valid, 0);
    check_val("mr_mdata",  m_data,  0);
    check_val("mr_mlast",  m_last,  0);
    check_val("mr_mabort", m_abort, 0);
    check_val("mr_grant",  grant,   0);
    check_val("mr_sready", s_ready, 0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive_src(0, 1, 64'hF8, 0, 1, 0);
    step();
    check_val("mr_first",  grant,   4'b0001);
    step();
    drive_src(0, 0, 0, 0, 0, 0);
    step();

    // Random traffic with aborts, stalls and backpressure.
    for (int k = 0; k < NIN; k++) begin
      gen_left[k]  = 0;
      gen_stall[k] = 0;
    end
    mode = 1;
    for (int c = 0; c < 3000; c++) begin
      gen_drive();
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/axinarbiter.md
# axinarbiter

Packet-atomic round-robin arbiter that merges NIN AXI-network (AXIN) packet streams onto one AXIN master port. It sits between the packet generators or CRC stages and a shared consumer, such as the CDC FIFO or the Ethernet transmit model. Once a source wins, the grant holds for its whole packet. A stall watchdog aborts a stalled packet and frees the port.

## Interface
- NIN, 4, number of input streams (2..8)
- DW, 64, data bits per beat
- BW, 3, BYTES width = log2(DW/8); BYTES==0 means all DW/8 bytes valid
- LGTIMEOUT, 10, watchdog width; a packet stalls out after 2^LGTIMEOUT-1 idle cycles
- S_AXI_ACLK  in  1  single clock for all ports
- S_AXI_ARESET  in  1  reset, asynchronous, active-high
- S_VALID  in  NIN  per-source beat valid
- S_READY  out  NIN  per-source beat accept
- S_DATA  in  NIN*DW  per-source data; source k occupies [k*DW +: DW]
- S_BYTES  in  NIN*BW  per-source byte count of the last beat
- S_LAST  in  NIN  per-source end of packet
- S_ABORT  in  NIN  per-source packet abort
- M_VALID  out  1  registered output valid
- M_READY  in  1  downstream accept
- M_DATA  out  DW  registered data
- M_BYTES  out  BW  registered byte count
- M_LAST  out  1  registered end of packet
- M_ABORT  out  1  one-cycle abort pulse
- o_grant  out  NIN  one-hot current grant; zero when idle
- o_timeout  out  1  one-cycle pulse when the watchdog fires

## Operation
- There are two states, IDLE and ACTIVE, plus a registered grant index `gnt` and a rotating pointer `last_gnt`.
- **IDLE**
  - If any S_VALID is high, pick the first requester after last_gnt, searching upward with wrap.
  - Load gnt, go to ACTIVE, and set last_gnt to the winner.
  - S_READY is all zero in IDLE.
- **ACTIVE**
  - S_READY[gnt] = !S_ABORT[gnt] && (!M_VALID || M_READY). All other S_READY bits are 0.
  - An accepted beat loads M_DATA, M_BYTES and M_LAST from source gnt and sets M_VALID.
  - M_VALID clears when M_READY is high and no new beat is loaded.
  - An accepted beat with S_LAST high moves the state to IDLE. The output register still drains that beat normally.
- **Source abort:** S_ABORT[gnt] high in ACTIVE has these effects:
  - M_ABORT pulses for 1 cycle.
  - M_VALID clears, discarding any pending beat.
  - The state moves to IDLE.
  - S_ABORT from non-granted sources, or in IDLE, is ignored.
- **Watchdog:**
  - The counter increments each ACTIVE cycle in which S_VALID[gnt] is low.
  - It clears on any accepted beat and on entry to ACTIVE.
  - Cycles stalled by M_READY low are not counted.
  - When the counter reaches all-ones, the block pulses M_ABORT and o_timeout together, clears M_VALID, and moves to IDLE.
- **M_VALID hold rule:** while M_VALID && !M_READY, M_DATA, M_BYTES and M_LAST hold stable. The only exception is an abort.

## Timing
- **Reset values:** state=IDLE, gnt=0, last_gnt=NIN-1 (so source 0 wins first), and M_VALID, M_LAST, M_ABORT, o_timeout, o_grant all 0. M_DATA and M_BYTES are 0.
- **Latency:** S_VALID rises in cycle 0 in IDLE. Grant and S_READY follow in cycle 1, and M_VALID in cycle 2.
- **Packet gap:** there is a one-cycle bubble between packets. The IDLE cycle is spent on arbitration.
- **Throughput:** 1 beat/cycle in ACTIVE with M_READY held high.
- **Simultaneous events:**
  - S_LAST and S_ABORT on the same granted cycle: abort wins and the beat is not accepted.
  - Beat acceptance and a watchdog terminal count in the same cycle: the beat is accepted, the counter clears, and no timeout fires.
  - Reset asserted mid-packet: all outputs clear immediately (asynchronous). No M_ABORT is emitted.
- **Pulse width:** M_ABORT and o_timeout are exactly 1 cycle each.

## Structure
- Shared package / header holds:
  - the state encodings AXA_IDLE=1'b0 and AXA_ACTIVE=1'b1;
  - the BYTES-width rule BW = log2(DW/8).
- Sub-module `axin_rrpick`: combinational rotate-priority picker taking request[NIN] and last[log2 NIN] and returning a one-hot grant and its index. It is reusable by other multi-port AXIN blocks.

## Test plan
- **Single packet:** S_VALID[2] sends a 3-beat packet with BYTES=0,0,5. Expect o_grant=4'b0100 in cycle 1, M_VALID in cycle 2, and 3 M beats with M_LAST on the third and M_BYTES=5.
- **Fairness:** all 4 sources continuously send 2-beat packets with M_READY=1. Expect the grant order 0,1,2,3,0, with a 1-cycle gap after each M_LAST, and no interleaving within a packet.
- **Backpressure:** hold M_READY=0 for 20 cycles mid-packet with LGTIMEOUT=4. Expect M_DATA to stay stable, S_READY=0 and no o_timeout. On release the packet completes intact.
- **Source abort:** source 1 asserts S_ABORT on its 2nd beat. Expect a 1-cycle M_ABORT pulse, M_VALID=0, and the grant moving to the next requester after one IDLE cycle.
- **Watchdog:** with LGTIMEOUT=4, source 0 drops S_VALID mid-packet. Expect M_ABORT and o_timeout together 15 cycles later, then IDLE.
- **Reset mid-packet:** assert S_AXI_ARESET during beat 2. Expect all outputs 0 in the same cycle. After release, the first grant goes to source 0.
